segre_mmu_arb: RTL and testbench

Parametrised memory-management front end sitting between NUM_CLIENTS cache controllers (data caches, instruction caches, and any future L1s) and the single-ported main memory. It accepts line-miss requests from every client and grants them round-robin. For each granted request it optionally writes back a dirty victim line, then fetches the missing line, and returns the line to the requesting client with a one-hot response pulse. Exactly one main-memory transaction is outstanding at any time.

---
 rtl/segre_pkg.sv | 17 +
 rtl/segre_rr_arbiter.sv | 41 ++++
 rtl/segre_mmu_arb.sv | 168 ++++++++++++++++
 tb/tb_segre_mmu_arb.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/segre_pkg.sv
// Shared types and default sizes for the segre memory-management front end.
package segre_pkg;

    localparam int MMU_NUM_CLIENTS  = 2;
    localparam int DCACHE_LANE_SIZE = 128;
    localparam int ADDR_SIZE        = 32;

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        WB_WAIT,
        RD_REQ,
        RD_WAIT,
        RESP
    } mmu_fsm_state_e;

endpackage

// File: rtl/segre_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps around.
// The first requester found yields a one-hot grant and its binary index.
module segre_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] cand [NUM_REQ];

    // cand[k] is the client examined k steps after ptr, modulo NUM_REQ.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum = {1'b0, ptr} + (IDX_W+1)'(gi);
            assign cand[gi] = (sum >= (IDX_W+1)'(NUM_REQ))
                            ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                            : sum[IDX_W-1:0];
        end
    endgenerate

    // Walk from the farthest candidate back so the nearest requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                grant_idx = cand[k];
            end
        end
        if (|req) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/segre_mmu_arb.sv
// Round-robin line-miss front end for a single-ported main memory.
// The optional dirty-victim writeback path is built when SEGRE_MMU_WRITEBACK_EN is defined.
module segre_mmu_arb
    import segre_pkg::*;
#(
    parameter int NUM_CLIENTS = MMU_NUM_CLIENTS,
    parameter int ADDR_W      = ADDR_SIZE,
    parameter int LINE_W      = DCACHE_LANE_SIZE,
    parameter int OFFSET_W    = 4
) (
    input  logic                          clk,
    input  logic                          rsn,
    input  logic [NUM_CLIENTS-1:0]        req_valid_i,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_CLIENTS-1:0]        req_wb_i,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] req_wb_addr_i,
    input  logic [NUM_CLIENTS*LINE_W-1:0] req_wb_data_i,
    output logic [NUM_CLIENTS-1:0]        req_ack_o,
    output logic [NUM_CLIENTS-1:0]        rsp_valid_o,
    output logic [ADDR_W-1:0]             rsp_addr_o,
    output logic [LINE_W-1:0]             rsp_data_o,
    output logic                          mm_rd_req_o,
    output logic                          mm_wr_req_o,
    output logic [ADDR_W-1:0]             mm_addr_o,
    output logic [LINE_W-1:0]             mm_data_o,
    input  logic                          mm_data_rdy_i,
    input  logic [LINE_W-1:0]             mm_data_i
);

    localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    mmu_fsm_state_e state_reg, state_next;

    logic [IDX_W-1:0]       rr_ptr_reg;
    logic [IDX_W-1:0]       gnt_reg;
    logic [IDX_W-1:0]       grant_idx;
    logic [NUM_CLIENTS-1:0] grant;
    logic [NUM_CLIENTS-1:0] ack_reg;
    logic [ADDR_W-1:0]      addr_reg;
    logic [LINE_W-1:0]      line_reg;
    logic [ADDR_W-1:0]      addr_arr [NUM_CLIENTS];
    logic                   any_req;
    logic                   take_wb;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        r = a;
        r[OFFSET_W-1:0] = '0;
        return r;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_addr
            assign addr_arr[gi] = req_addr_i[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    segre_rr_arbiter #(
        .NUM_REQ (NUM_CLIENTS),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req_valid_i),
        .ptr       (rr_ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign any_req = |req_valid_i;

`ifdef SEGRE_MMU_WRITEBACK_EN
    logic [ADDR_W-1:0] wb_addr_arr [NUM_CLIENTS];
    logic [LINE_W-1:0] wb_data_arr [NUM_CLIENTS];
    logic [ADDR_W-1:0] wb_addr_reg;
    logic [LINE_W-1:0] wb_data_reg;

    generate
        for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_wb
            assign wb_addr_arr[gi] = req_wb_addr_i[gi*ADDR_W +: ADDR_W];
            assign wb_data_arr[gi] = req_wb_data_i[gi*LINE_W +: LINE_W];
        end
    endgenerate

    assign take_wb = req_wb_i[grant_idx];

    always_ff @(posedge clk) begin
        if (!rsn) begin
            wb_addr_reg <= '0;
            wb_data_reg <= '0;
        end else if (state_reg == IDLE && any_req) begin
            wb_addr_reg <= wb_addr_arr[grant_idx];
            wb_data_reg <= wb_data_arr[grant_idx];
        end
    end

    assign mm_wr_req_o = (state_reg == WB_REQ);
    assign mm_data_o   = wb_data_reg;
`else
    logic unused_wb;
    assign unused_wb   = ^{req_wb_i, req_wb_addr_i, req_wb_data_i};
    assign take_wb     = 1'b0;
    assign mm_wr_req_o = 1'b0;
    assign mm_data_o   = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rsn) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= '0;
            gnt_reg    <= '0;
            ack_reg    <= '0;
            addr_reg   <= '0;
            line_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ack_reg   <= '0;
            if (state_reg == IDLE && any_req) begin
                gnt_reg  <= grant_idx;
                ack_reg  <= grant;
                addr_reg <= addr_arr[grant_idx];
            end
            if (state_reg == RD_WAIT && mm_data_rdy_i) begin
                line_reg <= mm_data_i;
            end
            if (state_reg == RESP) begin
                rr_ptr_reg <= (gnt_reg == IDX_W'(NUM_CLIENTS - 1)) ? '0 : gnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_req) state_next = take_wb ? WB_REQ : RD_REQ;
            WB_REQ:  state_next = WB_WAIT;
            WB_WAIT: if (mm_data_rdy_i) state_next = RD_REQ;
            RD_REQ:  state_next = RD_WAIT;
            RD_WAIT: if (mm_data_rdy_i) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The address bus carries the victim line while writing back, the miss line while reading.
    always_comb begin
        mm_addr_o = '0;
        case (state_reg)
`ifdef SEGRE_MMU_WRITEBACK_EN
            WB_REQ, WB_WAIT: mm_addr_o = line_align(wb_addr_reg);
`endif
            RD_REQ, RD_WAIT: mm_addr_o = line_align(addr_reg);
            default:         mm_addr_o = '0;
        endcase
    end

    always_comb begin
        rsp_valid_o = '0;
        if (state_reg == RESP) begin
            rsp_valid_o[gnt_reg] = 1'b1;
        end
    end

    assign req_ack_o   = ack_reg;
    assign mm_rd_req_o = (state_reg == RD_REQ);
    assign rsp_addr_o  = addr_reg;
    assign rsp_data_o  = line_reg;

endmodule

// File: tb/tb_segre_mmu_arb.sv
// Randomized bench for segre_mmu_arb against a transaction-level round-robin model.
module tb_segre_mmu_arb;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int LW = 128;
`ifdef SEGRE_MMU_WRITEBACK_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rsn;
    logic [N-1:0]    req_valid_i;
    logic [N*AW-1:0] req_addr_i;
    logic [N-1:0]    req_wb_i;
    logic [N*AW-1:0] req_wb_addr_i;
    logic [N*LW-1:0] req_wb_data_i;
    logic [N-1:0]    req_ack_o;
    logic [N-1:0]    rsp_valid_o;
    logic [AW-1:0]   rsp_addr_o;
    logic [LW-1:0]   rsp_data_o;
    logic            mm_rd_req_o;
    logic            mm_wr_req_o;
    logic [AW-1:0]   mm_addr_o;
    logic [LW-1:0]   mm_data_o;
    logic            mm_data_rdy_i;
    logic [LW-1:0]   mm_data_i;

    segre_mmu_arb #(.NUM_CLIENTS(N), .ADDR_W(AW), .LINE_W(LW), .OFFSET_W(4)) dut (
        .clk           (clk),
        .rsn           (rsn),
        .req_valid_i   (req_valid_i),
        .req_addr_i    (req_addr_i),
        .req_wb_i      (req_wb_i),
        .req_wb_addr_i (req_wb_addr_i),
        .req_wb_data_i (req_wb_data_i),
        .req_ack_o     (req_ack_o),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_addr_o    (rsp_addr_o),
        .rsp_data_o    (rsp_data_o),
        .mm_rd_req_o   (mm_rd_req_o),
        .mm_wr_req_o   (mm_wr_req_o),
        .mm_addr_o     (mm_addr_o),
        .mm_data_o     (mm_data_o),
        .mm_data_rdy_i (mm_data_rdy_i),
        .mm_data_i     (mm_data_i)
    );

    always #5 clk = ~clk;

    // Client-side view of outstanding misses and the model's round-robin pointer.
    bit          cl_valid  [N];
    logic [31:0] cl_addr   [N];
    bit          cl_wb     [N];
    logic [31:0] cl_wbaddr [N];
    logic [127:0] cl_wbdata [N];
    int          model_ptr;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int rsp_cnt = 0;

    always @(negedge clk) begin
        if (mm_rd_req_o === 1'b1) rd_cnt <= rd_cnt + 1;
        if (mm_wr_req_o === 1'b1) wr_cnt <= wr_cnt + 1;
        if (|rsp_valid_o) rsp_cnt <= rsp_cnt + 1;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [31:0] align(input logic [31:0] a);
        return a & 32'hFFFF_FFF0;
    endfunction

    function automatic int pick_winner();
        for (int k = 0; k < N; k++) begin
            if (cl_valid[(model_ptr + k) % N]) return (model_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_clients();
        for (int i = 0; i < N; i++) begin
            req_valid_i[i]            = cl_valid[i];
            req_addr_i[i*AW +: AW]    = cl_addr[i];
            req_wb_i[i]               = cl_wb[i];
            req_wb_addr_i[i*AW +: AW] = cl_wbaddr[i];
            req_wb_data_i[i*LW +: LW] = cl_wbdata[i];
        end
    endtask

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic apply_reset();
        rsn = 1'b0;
        mm_data_rdy_i = 1'b0;
        mm_data_i = '0;
        for (int i = 0; i < N; i++) begin
            cl_valid[i] = 1'b0;
        end
        drive_clients();
        tick();
        tick();
        check("rst_ack", req_ack_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_rsp_addr", rsp_addr_o, 0);
        check("rst_rsp_data", rsp_data_o, 0);
        check("rst_rd_req", mm_rd_req_o, 0);
        check("rst_wr_req", mm_wr_req_o, 0);
        check("rst_mm_addr", mm_addr_o, 0);
        check("rst_mm_data", mm_data_o, 0);
        rsn = 1'b1;
        model_ptr = 0;
    endtask

    task automatic set_client(input int c, input logic [31:0] a, input bit wb,
                              input logic [31:0] wa, input logic [127:0] wd);
        cl_valid[c]  = 1'b1;
        cl_addr[c]   = a;
        cl_wb[c]     = wb;
        cl_wbaddr[c] = wa;
        cl_wbdata[c] = wd;
    endtask

    // Entered in an IDLE cycle; returns in the IDLE cycle after the response.
    task automatic run_txn(input int lw, input int lr, input bit stray);
        int w;
        bit wb_exp;
        logic [N-1:0] oh;
        logic [127:0] d;
        int rd0, wr0, rsp0;
        w = pick_winner();
        if (w < 0) begin
            check("no_pending_client", 0, 1);
            finish_run();
        end
        wb_exp = WB_EN && cl_wb[w];
        oh = '0;
        oh[w] = 1'b1;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        rsp0 = rsp_cnt;
        drive_clients();
        tick();
        check("ack", req_ack_o, oh);
        cl_valid[w] = 1'b0;
        drive_clients();
        if (wb_exp) begin
            check("wr_req", mm_wr_req_o, 1);
            check("wr_addr", mm_addr_o, align(cl_wbaddr[w]));
            check("wr_data", mm_data_o, cl_wbdata[w]);
            check("wr_no_rd", mm_rd_req_o, 0);
            tick();
            check("ack_pulse", req_ack_o, 0);
            repeat (lw - 1) tick();
            mm_data_rdy_i = 1'b1;
            mm_data_i = rand_line();
            tick();
            mm_data_rdy_i = 1'b0;
        end
        check("rd_req", mm_rd_req_o, 1);
        check("rd_addr", mm_addr_o, align(cl_addr[w]));
        if (stray) begin
            mm_data_rdy_i = 1'b1;
            mm_data_i = rand_line();
        end
        tick();
        mm_data_rdy_i = 1'b0;
        if (!wb_exp) check("ack_pulse", req_ack_o, 0);
        repeat (lr - 1) tick();
        check("no_early_rsp", rsp_valid_o, 0);
        d = rand_line();
        mm_data_i = d;
        mm_data_rdy_i = 1'b1;
        tick();
        mm_data_rdy_i = 1'b0;
        check("rsp_valid", rsp_valid_o, oh);
        check("rsp_addr", rsp_addr_o, cl_addr[w]);
        check("rsp_data", rsp_data_o, d);
        tick();
        check("rsp_pulse", rsp_valid_o, 0);
        check("rd_count", rd_cnt - rd0, 1);
        check("wr_count", wr_cnt - wr0, wb_exp ? 1 : 0);
        check("rsp_count", rsp_cnt - rsp0, 1);
        model_ptr = (w + 1) % N;
        $display("txn client=%0d addr=%h wb=%0d lw=%0d lr=%0d stray=%0d", w, cl_addr[w], wb_exp, lw, lr, stray);
    endtask

    initial begin
        int rsp0, rd0;
        rsn = 1'b0;
        mm_data_rdy_i = 1'b0;
        mm_data_i = '0;
        for (int i = 0; i < N; i++) begin
            set_client(i, 32'h0, 1'b0, 32'h0, '0);
            cl_valid[i] = 1'b0;
        end
        drive_clients();
        apply_reset();

        // Stray memory-ready pulse while idle.
        rsp0 = rsp_cnt;
        mm_data_i = rand_line();
        mm_data_rdy_i = 1'b1;
        tick();
        mm_data_rdy_i = 1'b0;
        tick();
        tick();
        check("idle_stray_rsp", rsp_cnt - rsp0, 0);

        // Single read miss, latency 4.
        set_client(0, 32'h0000_1234, 1'b0, 32'h0, '0);
        run_txn(1, 4, 1'b0);

        // Pointer now at client 1: both requesting -> 1 then 0.
        set_client(0, 32'hA000_0010, 1'b0, 32'h0, '0);
        set_client(1, 32'hB000_002C, 1'b0, 32'h0, '0);
        run_txn(1, 2, 1'b0);
        run_txn(1, 1, 1'b1);

        // Simultaneous pairs after reset: 0,1 then 0,1 again.
        apply_reset();
        set_client(0, 32'h1111_1110, 1'b0, 32'h0, '0);
        set_client(1, 32'h2222_2224, 1'b0, 32'h0, '0);
        run_txn(1, 1, 1'b0);
        run_txn(1, 3, 1'b0);
        set_client(0, 32'h3333_3338, 1'b0, 32'h0, '0);
        set_client(1, 32'h4444_444C, 1'b0, 32'h0, '0);
        run_txn(1, 2, 1'b0);
        run_txn(1, 2, 1'b1);

        // Dirty victim on client 1.
        set_client(1, 32'h0000_3000, 1'b1, 32'h0000_2008, rand_line());
        run_txn(2, 2, 1'b0);

        // Reset while waiting for read data, then a fresh client-1 miss.
        set_client(0, 32'h0000_4444, 1'b0, 32'h0, '0);
        drive_clients();
        tick();
        check("mid_ack", req_ack_o, 2'b01);
        cl_valid[0] = 1'b0;
        drive_clients();
        tick();
        tick();
        apply_reset();
        rsp0 = rsp_cnt;
        rd0 = rd_cnt;
        mm_data_i = rand_line();
        mm_data_rdy_i = 1'b1;
        tick();
        mm_data_rdy_i = 1'b0;
        tick();
        tick();
        check("late_rdy_rsp", rsp_cnt - rsp0, 0);
        check("late_rdy_rd", rd_cnt - rd0, 0);
        set_client(1, 32'h0000_5558, 1'b0, 32'h0, '0);
        run_txn(1, 2, 1'b0);

        // Randomized traffic; unserved clients keep their request level.
        for (int it = 0; it < 40; it++) begin
            bit any;
            any = 1'b0;
            for (int c = 0; c < N; c++) begin
                if (!cl_valid[c] && ($urandom_range(0, 1) == 1)) begin
                    set_client(c, $urandom, $urandom_range(0, 1) == 1, $urandom, rand_line());
                end
                any = any | cl_valid[c];
            end
            if (!any) begin
                if ($urandom_range(0, 1) == 1) begin
                    rsp0 = rsp_cnt;
                    mm_data_i = rand_line();
                    mm_data_rdy_i = 1'b1;
                    tick();
                    mm_data_rdy_i = 1'b0;
                    tick();
                    check("rand_idle_stray", rsp_cnt - rsp0, 0);
                end
                set_client($urandom_range(0, N - 1), $urandom, $urandom_range(0, 1) == 1, $urandom, rand_line());
            end
            run_txn($urandom_range(1, 3), $urandom_range(1, 4), $urandom_range(0, 1) == 1);
        end

        finish_run();
    end

endmodule
